weights_loader: RTL and testbench

Write-side feeder for the weights memory. Accepts a byte stream from the host link (UART/SPI front end) after a `start` pulse and packs each three bytes into one 21-bit weight word. Drives the weights RAM write port (`address_in_weights`, `data_in_weights`, `we_weights`) with sequential addresses from 0 to `WORD_COUNT-1`, then reports completion to the layer sequencer.

---
 rtl/weights_loader.sv | 167 ++++++++++++++++
 tb/tb_weights_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/weights_loader.sv
// Weights RAM write-side loader: packs a host byte stream into DATA_W-bit words
// and writes them to addresses 0..WORD_COUNT-1. Optional macro WEIGHTS_CHECKSUM_EN adds a trailing XOR check byte.
module weights_loader #(
    parameter int DATA_W     = 21,
    parameter int ADDR_W     = 24,
    parameter int WORD_COUNT = 210852
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] address_in_weights,
    output logic [DATA_W-1:0] data_in_weights,
    output logic              we_weights,
    output logic              busy,
    output logic              done,
    output logic              checksum_error
);

    // state   | meaning
    // S_IDLE  | waiting for start after reset
    // S_LOAD  | accepting bytes, one RAM write per three bytes
    // S_CHECK | accepting the trailing XOR checksum byte (checksum build)
    // S_DONE  | load complete, done held until next start
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef WEIGHTS_CHECKSUM_EN
        S_CHECK = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    state_t              state_q;
    logic [1:0]          idx_q;
    logic [DATA_W-17:0]  b0_q;
    logic [7:0]          b1_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                we_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                last_q;
    logic                accept_d;
    logic [DATA_W-1:0]   word_d;

    assign accept_d = byte_valid & ready_q;
    assign word_d   = {b0_q, b1_q, byte_in};

`ifdef WEIGHTS_CHECKSUM_EN
    logic [7:0] xor_q;
    logic       err_q;
    assign checksum_error = err_q;
`else
    assign checksum_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            b0_q    <= '0;
            b1_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
`ifdef WEIGHTS_CHECKSUM_EN
            xor_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        idx_q   <= 2'd0;
                        addr_q  <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        last_q  <= 1'b0;
`ifdef WEIGHTS_CHECKSUM_EN
                        xor_q   <= '0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    // Write cycle: advance the address, or leave once the last word is out
                    if (we_q) begin
                        if (last_q) begin
`ifdef WEIGHTS_CHECKSUM_EN
                            state_q <= S_CHECK;
                            ready_q <= 1'b1;
`else
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                    if (accept_d) begin
`ifdef WEIGHTS_CHECKSUM_EN
                        xor_q <= xor_q ^ byte_in;
`endif
                        case (idx_q)
                            2'd0: begin
                                b0_q  <= byte_in[DATA_W-17:0];
                                idx_q <= 2'd1;
                            end
                            2'd1: begin
                                b1_q  <= byte_in;
                                idx_q <= 2'd2;
                            end
                            default: begin
                                data_q <= word_d;
                                we_q   <= 1'b1;
                                idx_q  <= 2'd0;
                                // No byte may be taken during the final write cycle
                                if (addr_q == LAST_ADDR) begin
                                    last_q  <= 1'b1;
                                    ready_q <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
`ifdef WEIGHTS_CHECKSUM_EN
                S_CHECK: begin
                    if (accept_d) begin
                        err_q   <= (byte_in != xor_q);
                        state_q <= S_DONE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready         = ready_q;
    assign address_in_weights = addr_q;
    assign data_in_weights    = data_q;
    assign we_weights         = we_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_weights_loader.sv
// Directed self-checking bench for weights_loader (small WORD_COUNT).
module tb_weights_loader;

    localparam int DW = 21;
    localparam int AW = 24;
`ifdef WEIGHTS_CHECKSUM_EN
    localparam int WC = 1;
`else
    localparam int WC = 4;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [AW-1:0] address_in_weights;
    logic [DW-1:0] data_in_weights;
    logic          we_weights;
    logic          busy;
    logic          done;
    logic          checksum_error;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    logic we_prev = 1'b0;

    weights_loader #(.DATA_W(DW), .ADDR_W(AW), .WORD_COUNT(WC)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .byte_in            (byte_in),
        .byte_valid         (byte_valid),
        .byte_ready         (byte_ready),
        .address_in_weights (address_in_weights),
        .data_in_weights    (data_in_weights),
        .we_weights         (we_weights),
        .busy               (busy),
        .done               (done),
        .checksum_error     (checksum_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every write pulse must be a single cycle and stay inside the address range
    always @(negedge clk) begin
        if (we_weights) begin
            check("we_one_cycle", 32'(we_prev), 32'd0);
            check("we_addr_range", 32'(address_in_weights <= AW'(WC - 1)), 32'd1);
            we_cnt++;
        end
        we_prev = we_weights;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"},    32'(we_weights), 32'd0);
        check({tag, "_addr"},  32'(address_in_weights), 32'd0);
        check({tag, "_data"},  32'(data_in_weights), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_cerr"},  32'(checksum_error), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        guard = 0;
        if (gaps) begin
            while ($urandom_range(1) == 1 && guard < 4) begin
                byte_valid = 1'b0;
                step();
                guard++;
            end
        end
        guard = 0;
        while (!byte_ready && guard < 50) begin
            byte_valid = 1'b0;
            step();
            guard++;
        end
        if (!byte_ready) check("ready_timeout", 32'd0, 32'd1);
        byte_in    = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int ea, input logic [DW-1:0] ed, input bit gaps);
        send_byte(b0, gaps);
        send_byte(b1, gaps);
        send_byte(b2, gaps);
        check("wr_we",   32'(we_weights), 32'd1);
        check("wr_addr", 32'(address_in_weights), 32'(ea));
        check("wr_data", 32'(data_in_weights), 32'(ed));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

`ifndef WEIGHTS_CHECKSUM_EN
    logic [7:0]    stim [12] = '{8'h01, 8'h23, 8'h45, 8'hFF, 8'hFF, 8'hFF,
                                 8'h00, 8'h00, 8'h01, 8'h10, 8'h00, 8'h00};
    logic [DW-1:0] expw [4]  = '{21'h012345, 21'h1FFFFF, 21'h000001, 21'h100000};

    task automatic load_words(input int first, input bit gaps);
        for (int w = first; w < 4; w++)
            send_word(stim[3*w], stim[3*w+1], stim[3*w+2], w, expw[w], gaps);
        step();
        check("done_after_last", 32'(done), 32'd1);
        check("busy_after_last", 32'(busy), 32'd0);
        check("ready_after_last", 32'(byte_ready), 32'd0);
    endtask
`endif

    initial begin
        step();
        step();
        check_reset_vals("rst");
        // reset and start together: reset wins
        start = 1'b1;
        step();
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();
        check("idle_ready", 32'(byte_ready), 32'd0);

`ifndef WEIGHTS_CHECKSUM_EN
        // back-to-back stream
        pulse_start();
        check("start_busy",  32'(busy), 32'd1);
        check("start_ready", 32'(byte_ready), 32'd1);
        check("start_done",  32'(done), 32'd0);
        load_words(0, 1'b0);
        check("we_count_1", 32'(we_cnt), 32'd4);

        // gapped stream
        pulse_start();
        check("restart_done", 32'(done), 32'd0);
        load_words(0, 1'b1);
        check("we_count_2", 32'(we_cnt), 32'd8);

        // reset after five accepted bytes
        pulse_start();
        send_word(stim[0], stim[1], stim[2], 0, expw[0], 1'b0);
        send_byte(stim[3], 1'b0);
        send_byte(stim[4], 1'b0);
        reset = 1'b1;
        step();
        check_reset_vals("midrst");
        reset = 1'b0;
        step();
        step();
        step();
        check("we_count_3", 32'(we_cnt), 32'd9);
        pulse_start();
        load_words(0, 1'b0);
        check("we_count_4", 32'(we_cnt), 32'd13);

        // start during load is ignored, start in DONE restarts
        pulse_start();
        send_word(stim[0], stim[1], stim[2], 0, expw[0], 1'b0);
        send_word(stim[3], stim[4], stim[5], 1, expw[1], 1'b0);
        pulse_start();
        check("midstart_addr", 32'(address_in_weights), 32'd2);
        check("midstart_busy", 32'(busy), 32'd1);
        load_words(2, 1'b0);
        check("we_count_5", 32'(we_cnt), 32'd17);

        // extra byte in DONE is not consumed
        byte_in    = 8'hAA;
        byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("extra_ready", 32'(byte_ready), 32'd0);
            check("extra_done",  32'(done), 32'd1);
            check("extra_cerr",  32'(checksum_error), 32'd0);
        end
        start = 1'b1;
        step();
        start      = 1'b0;
        byte_valid = 1'b0;
        check("redo_done",  32'(done), 32'd0);
        check("redo_busy",  32'(busy), 32'd1);
        check("redo_addr",  32'(address_in_weights), 32'd0);
        check("redo_ready", 32'(byte_ready), 32'd1);
        load_words(0, 1'b0);
        check("we_count_6", 32'(we_cnt), 32'd21);
`else
        // correct checksum: 01^02^03 = 00
        pulse_start();
        send_word(8'h01, 8'h02, 8'h03, 0, 21'h010203, 1'b0);
        send_byte(8'h00, 1'b0);
        check("ck_ok_done", 32'(done), 32'd1);
        check("ck_ok_busy", 32'(busy), 32'd0);
        check("ck_ok_err",  32'(checksum_error), 32'd0);
        // wrong checksum
        pulse_start();
        check("ck_restart_err", 32'(checksum_error), 32'd0);
        send_word(8'h01, 8'h02, 8'h03, 0, 21'h010203, 1'b0);
        send_byte(8'h01, 1'b0);
        check("ck_bad_done", 32'(done), 32'd1);
        check("ck_bad_err",  32'(checksum_error), 32'd1);
        step();
        check("ck_bad_hold", 32'(checksum_error), 32'd1);
        check("ck_we_count", 32'(we_cnt), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
